// File: rtl/cpu_pio_pkg.sv
// Shared constants for the CPU input PIO: Avalon register offsets and edge-type encodings.
package cpu_pio_pkg;

  localparam logic [1:0] PIO_DATA = 2'd0;
  localparam logic [1:0] PIO_RSVD = 2'd1;
  localparam logic [1:0] PIO_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Cycles of edge suppression after reset release, so the synchronizer fills without false edges.
  localparam logic [1:0] WARMUP_CYCLES = 2'd3;

endpackage

// File: rtl/cpu_pio_sync.sv
// Parameterized-width two-flop synchronizer with synchronous active-low reset.
module cpu_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_sync0;
  logic [WIDTH-1:0] r_sync1;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
    end else begin
      r_sync0 <= i_async;
      r_sync1 <= r_sync0;
    end
  end

  assign o_sync = r_sync1;

endmodule

// File: rtl/cpu_input_pio.sv
// Avalon-MM edge-capturing input PIO with masked level interrupt.
// Build option: CPU_INPUT_PIO_BIT_CLEAR_EN selects per-bit clear of edge_capture (default: clear-all).
module cpu_input_pio
  import cpu_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int EDGE_TYPE  = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] w_sync1;
  logic [DATA_WIDTH-1:0] w_edge_raw;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [31:0]           w_rd_mux;
  logic                  w_wr;
  logic                  w_warm_done;

  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [31:0]           r_readdata;
  logic                  r_irq;
  logic [1:0]            r_warm;

  cpu_pio_sync #(.WIDTH(DATA_WIDTH)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (in_port),
    .o_sync  (w_sync1)
  );

  assign w_wr        = chipselect && !write_n;
  assign w_warm_done = (r_warm == 2'd0);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_edge_raw = '0;
    case (EDGE_TYPE)
      EDGE_RISE: w_edge_raw = w_sync1 & ~r_prev;
      EDGE_FALL: w_edge_raw = ~w_sync1 & r_prev;
      default:   w_edge_raw = w_sync1 ^ r_prev;
    endcase
  end

  assign w_edge = w_warm_done ? w_edge_raw : '0;

`ifdef CPU_INPUT_PIO_BIT_CLEAR_EN
  assign w_clr = (w_wr && address == PIO_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;
`else
  assign w_clr = (w_wr && address == PIO_EDGE) ? '1 : '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (address)
      PIO_DATA: w_rd_mux[DATA_WIDTH-1:0] = w_sync1;
      PIO_MASK: w_rd_mux[DATA_WIDTH-1:0] = r_mask;
      PIO_EDGE: w_rd_mux[DATA_WIDTH-1:0] = r_cap;
      default:  w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
      r_warm     <= WARMUP_CYCLES;
    end else begin
      r_prev     <= w_sync1;
      // Set after clear: an edge arriving with a clear write is kept.
      r_cap      <= (r_cap & ~w_clr) | w_edge;
      r_readdata <= w_rd_mux;
      r_irq      <= |(r_cap & r_mask);
      if (!w_warm_done)
        r_warm <= r_warm - 2'd1;
      if (w_wr && address == PIO_MASK)
        r_mask <= writedata[DATA_WIDTH-1:0];
    end
  end

  // Write-data bits above DATA_WIDTH carry no meaning for this block.
  if (DATA_WIDTH < 32) begin : g_unused_wdata
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:DATA_WIDTH];
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_cpu_input_pio.sv
// Self-checking bench: three DUTs (rising/falling/any edge) against a delay-line reference model.
module tb_cpu_input_pio;

  localparam int DW = 8;

`ifdef CPU_INPUT_PIO_BIT_CLEAR_EN
  localparam bit BIT_CLEAR = 1'b1;
`else
  localparam bit BIT_CLEAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [DW-1:0] in_port;
  logic [2:0][31:0] rd_o;
  logic [2:0]       irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cpu_input_pio #(.DATA_WIDTH(DW), .EDGE_TYPE(g)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (rd_o[g]),
      .irq        (irq_o[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: in_port seen at past edges is a delay line; register effects follow the map.
  logic [DW-1:0] h1, h2, h3;
  int            m_n;
  logic [DW-1:0] m_mask;
  logic [DW-1:0] m_cap [3];
  logic [31:0]   m_rd  [3];
  logic          m_irq [3];
  bit            m_valid = 1'b0;

  function automatic logic [DW-1:0] edge_of(input int t, input logic [DW-1:0] cur, input logic [DW-1:0] old);
    if (t == 0) return cur & ~old;
    if (t == 1) return ~cur & old;
    return cur ^ old;
  endfunction

  task automatic model_step();
    logic [DW-1:0] clr;
    logic [DW-1:0] ed;
    bit            wr;
    if (!reset_n) begin
      h1 = '0; h2 = '0; h3 = '0; m_n = 0; m_mask = '0;
      for (int g = 0; g < 3; g++) begin
        m_cap[g] = '0; m_rd[g] = '0; m_irq[g] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      if (m_n < 100) m_n++;
      wr  = chipselect && !write_n;
      clr = '0;
      if (wr && address == 2'd3) clr = BIT_CLEAR ? writedata[DW-1:0] : '1;
      for (int g = 0; g < 3; g++) begin
        case (address)
          2'd0:    m_rd[g] = 32'(h2);
          2'd2:    m_rd[g] = 32'(m_mask);
          2'd3:    m_rd[g] = 32'(m_cap[g]);
          default: m_rd[g] = 32'd0;
        endcase
        m_irq[g] = |(m_cap[g] & m_mask);
        ed = (m_n >= 4) ? edge_of(g, h2, h3) : '0;
        m_cap[g] = (m_cap[g] & ~clr) | ed;
      end
      if (wr && address == 2'd2) m_mask = writedata[DW-1:0];
      h3 = h2; h2 = h1; h1 = in_port;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int g = 0; g < 3; g++) begin
        check($sformatf("model_rdata[%0d]", g), rd_o[g], m_rd[g]);
        check($sformatf("model_irq[%0d]", g), 32'(irq_o[g]), 32'(m_irq[g]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'hFF;
    tick(3);
    check("rst_rdata", rd_o[0], 32'h0);
    check("rst_irq", 32'(irq_o[0]), 32'h0);

    // Static inputs across reset release must not capture.
    reset_n = 1'b1;
    tick(10);
    address = 2'd3;
    tick(1);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("warmup_cap[%0d]", g), rd_o[g], 32'h0);
      check($sformatf("warmup_irq[%0d]", g), 32'(irq_o[g]), 32'h0);
    end

    // Capture timing on bit0 with mask 0x01.
    in_port = 8'h00;
    tick(5);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h01);
    tick(2);
    in_port = 8'h01;
    tick(2);
    check("cap_irq_k1", 32'(irq_o[0]), 32'h0);
    address = 2'd3;
    tick(1);
    check("cap_irq_k2", 32'(irq_o[0]), 32'h0);
    tick(1);
    check("cap_irq_k3", 32'(irq_o[0]), 32'h1);
    check("cap_value", rd_o[0], 32'h01);
    address = 2'd0;
    tick(1);
    check("data_read", rd_o[0], 32'h01);

    // Partial clear.
    in_port = 8'h05;
    tick(4);
    address = 2'd3;
    tick(1);
    check("cap_05", rd_o[0], 32'h05);
    wr(2'd3, 32'h01);
    tick(1);
    check("clr_cap", rd_o[0], BIT_CLEAR ? 32'h04 : 32'h00);
    check("clr_irq", 32'(irq_o[0]), 32'h0);
    wr(2'd2, 32'h04);
    tick(1);
    check("mask4_irq", 32'(irq_o[0]), BIT_CLEAR ? 32'h1 : 32'h0);

    // Edge detect and clear-all on the same clock.
    in_port = 8'h01;
    tick(4);
    wr(2'd3, 32'hFF);
    tick(1);
    in_port = 8'h05;
    tick(2);
    wr(2'd3, 32'hFF);
    tick(1);
    check("collision_cap", rd_o[0], 32'h04);

    // Any-edge instance captures both directions of bit3.
    wr(2'd3, 32'hFF);
    in_port = 8'h0D;
    tick(4);
    address = 2'd3;
    tick(1);
    check("any_rise", rd_o[2], 32'h08);
    check("fall_none", rd_o[1], 32'h00);
    wr(2'd3, 32'hFF);
    in_port = 8'h05;
    tick(5);
    check("any_fall", rd_o[2], 32'h08);
    check("fall_bit3", rd_o[1], 32'h08);
    check("rise_none", rd_o[0], 32'h00);

    // Read latency.
    wr(2'd2, 32'hA5);
    address = 2'd2;
    tick(1);
    check("mask_read", rd_o[0], 32'h000000A5);
    address = 2'd1;
    tick(1);
    check("rsvd_read", rd_o[0], 32'h0);

    // Mid-operation reset discards state.
    reset_n = 1'b0;
    tick(1);
    check("midrst_rdata", rd_o[0], 32'h0);
    check("midrst_irq", 32'(irq_o[0]), 32'h0);
    reset_n = 1'b1;
    address = 2'd2;
    tick(1);
    check("midrst_mask", rd_o[0], 32'h0);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = DW'($urandom);
      chipselect = 1'($urandom);
      write_n    = 1'($urandom);
      address    = 2'($urandom);
      writedata  = $urandom;
      reset_n    = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
